// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the single-port data memory: round-robin grant,
// bounded lock for atomic read-modify-write, 1-cycle registered response.
//
// state  | meaning
// IDLE   | no owner, round-robin between A and B
// LOCK_A | A owns the memory until it drops a_lock or lock_cnt hits LOCK_MAX
// LOCK_B | B owns the memory until it drops b_lock or lock_cnt hits LOCK_MAX
module dmem_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int MEM      = 64,
  parameter int LOCK_MAX = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic              a_lock,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_err,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  input  logic              b_lock,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rd
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(LOCK_MAX);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
  localparam logic [ADDR_W-1:0] MEM_LIM = ADDR_W'(MEM);

  typedef enum logic [1:0] {IDLE, LOCK_A, LOCK_B} state_t;

  state_t            state, state_nxt;
  logic              rr_last, rr_nxt;   // 1 = B was granted last
  logic [CNT_W-1:0]  lock_cnt, cnt_nxt;
  logic [ADDR_W-1:0] addr_q, sel_addr;
  logic [DATA_W-1:0] wdata_q, sel_wdata;
  logic              sel_we, sel_oor, grant;

  always_comb begin
    state_nxt = state;
    rr_nxt    = rr_last;
    cnt_nxt   = lock_cnt;
    a_ready   = 1'b0;
    b_ready   = 1'b0;
    // Gating on reset keeps every grant-derived output low during async reset.
    if (reset) begin
      case (state)
        IDLE: begin
          cnt_nxt = '0;
          a_ready = a_valid && (!b_valid || rr_last);
          b_ready = b_valid && (!a_valid || !rr_last);
          if (a_ready) begin
            rr_nxt = 1'b0;
            if (a_lock) begin
              state_nxt = LOCK_A;
              cnt_nxt   = CNT_ONE;
            end
          end else if (b_ready) begin
            rr_nxt = 1'b1;
            if (b_lock) begin
              state_nxt = LOCK_B;
              cnt_nxt   = CNT_ONE;
            end
          end
        end
        LOCK_A: begin
          if (lock_cnt == CNT_MAX) begin
            state_nxt = IDLE;
            rr_nxt    = 1'b0;
            cnt_nxt   = '0;
          end else begin
            a_ready = a_valid;
            cnt_nxt = lock_cnt + CNT_ONE;
            if (a_ready) rr_nxt = 1'b0;
            if (!a_lock) begin
              state_nxt = IDLE;
              cnt_nxt   = '0;
            end
          end
        end
        LOCK_B: begin
          if (lock_cnt == CNT_MAX) begin
            state_nxt = IDLE;
            rr_nxt    = 1'b1;
            cnt_nxt   = '0;
          end else begin
            b_ready = b_valid;
            cnt_nxt = lock_cnt + CNT_ONE;
            if (b_ready) rr_nxt = 1'b1;
            if (!b_lock) begin
              state_nxt = IDLE;
              cnt_nxt   = '0;
            end
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_comb begin
    grant     = a_ready || b_ready;
    sel_addr  = b_ready ? b_addr  : a_addr;
    sel_wdata = b_ready ? b_wdata : a_wdata;
    sel_we    = b_ready ? b_we    : a_we;
    sel_oor   = sel_addr >= MEM_LIM;
    mem_addr  = grant ? sel_addr  : addr_q;
    mem_wdata = grant ? sel_wdata : wdata_q;
    mem_we    = grant && sel_we && !sel_oor;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      rr_last  <= 1'b1;
      lock_cnt <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_err    <= 1'b0;
      b_err    <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
    end else begin
      state    <= state_nxt;
      rr_last  <= rr_nxt;
      lock_cnt <= cnt_nxt;
      if (grant) begin
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
      end
      a_rvalid <= a_ready;
      b_rvalid <= b_ready;
      a_err    <= a_ready && sel_oor;
      b_err    <= b_ready && sel_oor;
      a_rdata  <= (a_ready && !sel_we && !sel_oor) ? mem_rd : '0;
      b_rdata  <= (b_ready && !sel_we && !sel_oor) ? mem_rd : '0;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural memory, response scoreboard per port,
// directed grant-order checks for contention, lock, timeout and reset.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid, a_ready, a_we, a_lock, a_rvalid, a_err;
  logic        b_valid, b_ready, b_we, b_lock, b_rvalid, b_err;
  logic [31:0] a_addr, a_wdata, a_rdata, b_addr, b_wdata, b_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rd;
  logic        mem_we;

  always #5 clk = ~clk;

  dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .MEM(64), .LOCK_MAX(16)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_addr(a_addr),
    .a_wdata(a_wdata), .a_lock(a_lock), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .a_err(a_err),
    .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_addr(b_addr),
    .b_wdata(b_wdata), .b_lock(b_lock), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .b_err(b_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rd(mem_rd)
  );

  logic [31:0] mem [64];
  assign mem_rd = (mem_addr < 32'd64) ? mem[mem_addr[5:0]] : 32'h0;

  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h100 + i;
    end else if (mem_we && mem_addr < 32'd64) begin
      mem[mem_addr[5:0]] <= mem_wdata;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: expected {err, rdata} per port, pushed on grant, popped on rvalid.
  logic [32:0] qa[$], qb[$];
  logic [31:0] ref_mem [64];
  int          we_cnt = 0;

  function automatic logic [32:0] exp_resp(input logic we, input logic [31:0] addr);
    if (addr >= 32'd64) return {1'b1, 32'h0};
    if (we) return {1'b0, 32'h0};
    return {1'b0, ref_mem[addr[5:0]]};
  endfunction

  always @(negedge clk) begin : monitor
    logic ma, mb, exp_we;
    logic [32:0] e;
    if (!reset) begin
      qa.delete();
      qb.delete();
      for (int i = 0; i < 64; i++) ref_mem[i] = 32'h100 + i;
    end else begin
      check("a_rvalid", a_rvalid, qa.size() != 0);
      if (qa.size() != 0) begin
        e = qa.pop_front();
        if (a_rvalid) begin
          check("a_rdata", a_rdata, e[31:0]);
          check("a_err", a_err, e[32]);
        end
      end
      check("b_rvalid", b_rvalid, qb.size() != 0);
      if (qb.size() != 0) begin
        e = qb.pop_front();
        if (b_rvalid) begin
          check("b_rdata", b_rdata, e[31:0]);
          check("b_err", b_err, e[32]);
        end
      end
      ma = a_valid && a_ready;
      mb = b_valid && b_ready;
      check("one_grant", ma && mb, 1'b0);
      exp_we = (ma && a_we && a_addr < 32'd64) || (mb && b_we && b_addr < 32'd64);
      check("mem_we", mem_we, exp_we);
      if (mem_we) we_cnt++;
      if (ma) begin
        check("mem_addr_a", mem_addr, a_addr);
        if (a_we) check("mem_wdata_a", mem_wdata, a_wdata);
        qa.push_back(exp_resp(a_we, a_addr));
        if (a_we && a_addr < 32'd64) ref_mem[a_addr[5:0]] = a_wdata;
      end
      if (mb) begin
        check("mem_addr_b", mem_addr, b_addr);
        if (b_we) check("mem_wdata_b", mem_wdata, b_wdata);
        qb.push_back(exp_resp(b_we, b_addr));
        if (b_we && b_addr < 32'd64) ref_mem[b_addr[5:0]] = b_wdata;
      end
    end
  end

  task automatic drv_a(input logic v, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic lk);
    a_valid = v; a_we = we; a_addr = addr; a_wdata = wdata; a_lock = lk;
  endtask

  task automatic drv_b(input logic v, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic lk);
    b_valid = v; b_we = we; b_addr = addr; b_wdata = wdata; b_lock = lk;
  endtask

  task automatic cycle(output logic ga, output logic gb);
    @(negedge clk);
    ga = a_valid && a_ready;
    gb = b_valid && b_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ctl"}, {a_ready, b_ready, a_rvalid, b_rvalid, a_err, b_err, mem_we}, 7'b0);
    check({tag, "_rdata"}, {a_rdata, b_rdata}, 64'h0);
    check({tag, "_mem"}, {mem_addr, mem_wdata}, 64'h0);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "bench timeout");
  end

  initial begin : main
    logic ga, gb;
    int   w0, aaddr, baddr, gbk;
    reset = 1'b0;
    drv_a(0, 0, 0, 0, 0);
    drv_b(0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    reset = 1'b1;

    // Single write then read on A.
    w0 = we_cnt;
    drv_a(1, 1, 5, 32'hDEADBEEF, 0);
    cycle(ga, gb);
    check("t1_wr_gnt", ga, 1'b1);
    drv_a(1, 0, 5, 0, 0);
    cycle(ga, gb);
    check("t1_rd_gnt", ga, 1'b1);
    check("t1_rvalid", a_rvalid, 1'b1);
    check("t1_rdata", a_rdata, 32'hDEADBEEF);
    check("t1_err", a_err, 1'b0);
    check("t1_we_cnt", we_cnt - w0, 1);
    drv_a(0, 0, 0, 0, 0);
    drv_b(1, 0, 5, 0, 0);
    cycle(ga, gb);
    check("t1_b_gnt", gb, 1'b1);

    // Contention: alternating grants starting from A.
    aaddr = 0;
    baddr = 1;
    for (int i = 0; i < 4; i++) begin
      drv_a(1, 1, aaddr, 32'hA000_0000 | aaddr, 0);
      drv_b(1, 1, baddr, 32'hB000_0000 | baddr, 0);
      cycle(ga, gb);
      check("t2_gnt", {ga, gb}, (i % 2 == 0) ? 2'b10 : 2'b01);
      if (ga) aaddr += 2;
      if (gb) baddr += 2;
    end
    drv_a(0, 0, 0, 0, 0);
    drv_b(0, 0, 0, 0, 0);
    cycle(ga, gb);

    // Atomic RMW on B while A keeps asking.
    drv_b(1, 0, 10, 0, 1);
    cycle(ga, gb);
    check("t3_b_rd", gb, 1'b1);
    drv_a(1, 0, 20, 0, 0);
    drv_b(0, 0, 10, 0, 1);
    for (int i = 0; i < 2; i++) begin
      cycle(ga, gb);
      check("t3_a_held", ga, 1'b0);
    end
    drv_b(1, 1, 10, 32'h55AA_0000, 0);
    cycle(ga, gb);
    check("t3_b_wr", {ga, gb}, 2'b01);
    drv_b(0, 0, 0, 0, 0);
    cycle(ga, gb);
    check("t3_a_after", ga, 1'b1);
    drv_a(0, 0, 0, 0, 0);
    cycle(ga, gb);
    check("t3_mem10", mem[10], 32'h55AA_0000);

    // Lock timeout: A holds the lock with back-to-back requests.
    drv_a(1, 0, 0, 0, 1);
    cycle(ga, gb);
    check("t4_first", ga, 1'b1);
    gbk = 99;
    for (int k = 1; k <= 20; k++) begin
      drv_a(1, 0, k, 0, 1);
      drv_b(1, 0, 7, 0, 0);
      cycle(ga, gb);
      if (k < 16) check("t4_locked", {ga, gb}, 2'b10);
      if (k == 16) check("t4_a_at_max", ga, 1'b0);
      if (gb) begin
        gbk = k;
        break;
      end
    end
    check("t4_b_by_17", (gbk >= 1 && gbk <= 17), 1'b1);
    drv_a(0, 0, 0, 0, 0);
    drv_b(0, 0, 0, 0, 0);
    cycle(ga, gb);

    // Out-of-range writes, then an unaffected read of addr 0.
    drv_b(1, 1, 64, 32'h1234, 0);
    cycle(ga, gb);
    check("t5_b_gnt", gb, 1'b1);
    check("t5_rvalid", b_rvalid, 1'b1);
    check("t5_err", b_err, 1'b1);
    check("t5_rdata", b_rdata, 32'h0);
    drv_b(1, 1, 32'h8000_0005, 32'hBAD, 0);
    cycle(ga, gb);
    check("t5_wide_err", b_err, 1'b1);
    drv_b(0, 0, 0, 0, 0);
    drv_a(1, 0, 0, 0, 0);
    cycle(ga, gb);
    check("t5_rd0", a_rdata, 32'hA000_0000);
    check("t5_mem5", mem[5], 32'hDEADBEEF);
    drv_a(0, 0, 0, 0, 0);
    cycle(ga, gb);

    // Reset while LOCK_A with a response pending.
    drv_a(1, 1, 12, 32'h00C0FFEE, 1);
    cycle(ga, gb);
    check("t6_lock_gnt", ga, 1'b1);
    check("t6_pending", a_rvalid, 1'b1);
    reset = 1'b0;
    #1;
    check_quiet("t6_reset");
    @(posedge clk);
    #1;
    reset = 1'b1;
    drv_a(1, 0, 3, 0, 0);
    drv_b(1, 0, 4, 0, 0);
    cycle(ga, gb);
    check("t6_a_first", {ga, gb}, 2'b10);
    cycle(ga, gb);
    check("t6_b_next", {ga, gb}, 2'b01);
    drv_a(0, 0, 0, 0, 0);
    drv_b(0, 0, 0, 0, 0);
    repeat (2) cycle(ga, gb);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
